// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and the pure immediate decode used by the pipelined
// immediate generator and its consumers.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_fmt_e;

    // Widest supported XLEN; imm_extend always returns this many bits and
    // callers truncate, which is exact because every format sign-extends.
    localparam int IMM_MAX_W = 64;

    // Encodings 101..111 carry no immediate.
    function automatic logic imm_fmt_legal(input logic [2:0] fmt);
        return fmt <= IMM_U;
    endfunction

    // instr holds instruction bits [31:7]; instruction bit k sits at index k-7.
    function automatic logic [IMM_MAX_W-1:0] imm_extend(input logic [2:0]  fmt,
                                                        input logic [24:0] instr);
        logic [31:0] imm32;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[24]}}, instr[24:13]};
            IMM_S:   imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            IMM_B:   imm32 = {{19{instr[24]}}, instr[24], instr[0], instr[23:18],
                              instr[4:1], 1'b0};
            IMM_J:   imm32 = {{11{instr[24]}}, instr[24], instr[12:5], instr[13],
                              instr[23:14], 1'b0};
            IMM_U:   imm32 = {instr[24:5], 12'b0};
            default: imm32 = '0;
        endcase
        return {{(IMM_MAX_W-32){imm32[31]}}, imm32};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of the immediate generator: decode-side input beat,
// execute-side output beat and the sticky illegal-select flag.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_immsrc;
    logic [24:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_immext;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             err_sticky;
    logic             err_clr;

    // Producer/consumer side (drives beats in, takes beats out).
    modport master (
        output in_valid, in_immsrc, in_instr, in_tag, out_ready, err_clr,
        input  in_ready, out_valid, out_immext, out_tag, out_illegal, err_sticky
    );

    // The generator itself.
    modport slave (
        input  in_valid, in_immsrc, in_instr, in_tag, out_ready, err_clr,
        output in_ready, out_valid, out_immext, out_tag, out_illegal, err_sticky
    );
endinterface

// File: rtl/imm_gen_pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer. M drives the outputs; S catches the
// one beat that can arrive while M is stalled. in_ready is a pure flop.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [W-1:0] m_q, m_d, s_q, s_d;
    logic         accept, m_free;

    // Next state: M refills from S first, then from the input; a stalled M
    // diverts the incoming beat into S.
    always_comb begin
        m_vld_d = m_vld_q;
        m_d     = m_q;
        s_vld_d = s_vld_q;
        s_d     = s_q;
        accept  = in_valid_i && !s_vld_q;
        m_free  = !m_vld_q || out_ready_i;
        if (m_free) begin
            if (s_vld_q) begin
                m_vld_d = 1'b1;
                m_d     = s_q;
                s_vld_d = 1'b0;
            end else if (accept) begin
                m_vld_d = 1'b1;
                m_d     = in_data_i;
            end else begin
                m_vld_d = 1'b0;
            end
        end else if (accept) begin
            s_vld_d = 1'b1;
            s_d     = in_data_i;
        end
    end

    // State registers; reset discards any beats in flight and clears data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign in_ready_o  = !s_vld_q;
    assign out_valid_o = m_vld_q;
    assign out_data_o  = m_q;
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes and sign-extends at the input,
// then buffers the finished beat in a 2-entry skid buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    imm_gen_pipe_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0]  immext;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } beat_t;

    beat_t in_beat, out_beat;
    logic  in_ready, out_valid, accept;
    logic  err_d, err_q;

    // Build the stored beat; illegal selects decode to a zero immediate.
    always_comb begin
        in_beat.immext  = XLEN'(imm_extend(bus.in_immsrc, bus.in_instr));
        in_beat.tag     = bus.in_tag;
        in_beat.illegal = !imm_fmt_legal(bus.in_immsrc);
    end

    skid_buf #(.W($bits(beat_t))) u_skid (
        .clk_i      (clk),
        .rst_i      (reset),
        .in_valid_i (bus.in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_beat),
        .out_valid_o(out_valid),
        .out_ready_i(bus.out_ready),
        .out_data_o (out_beat)
    );

    // Sticky error: a clear in the same cycle beats a new illegal accept.
    always_comb begin
        accept = bus.in_valid && in_ready;
        err_d  = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end else if (accept && in_beat.illegal) begin
            err_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_immext  = out_beat.immext;
    assign bus.out_tag     = out_beat.tag;
    assign bus.out_illegal = out_beat.illegal;
    assign bus.err_sticky  = err_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep,
// checked every cycle against a queue model plus directed literal values.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, err_clr;
    logic [2:0]  in_immsrc;
    logic [31:0] in_word;
    logic [4:0]  in_tag;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic err_m;
    int   log_tag[$];
    int   log_cyc[$];

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.in_immsrc = in_immsrc;
    assign b32.in_instr  = in_word[31:7];
    assign b32.in_tag    = in_tag;
    assign b32.out_ready = out_ready;
    assign b32.err_clr   = err_clr;
    assign b64.in_valid  = in_valid;
    assign b64.in_immsrc = in_immsrc;
    assign b64.in_instr  = in_word[31:7];
    assign b64.in_tag    = in_tag;
    assign b64.out_ready = out_ready;
    assign b64.err_clr   = err_clr;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset(reset), .bus(b64));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference immediates taken straight from the full instruction word by
    // arithmetic shifts of the sign-extended instruction.
    function automatic logic [63:0] model_imm(input logic [2:0] f, input logic [31:0] ins);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        s = $signed({{32{ins[31]}}, ins});
        case (f)
            3'd0: begin hi = s >>> 20; return hi; end
            3'd1: begin hi = s >>> 25; return (hi << 5) | 64'(ins[11:7]); end
            3'd2: begin
                hi = s >>> 31;
                return (hi << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                       | (64'(ins[11:8]) << 1);
            end
            3'd3: begin
                hi = s >>> 31;
                return (hi << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                       | (64'(ins[30:21]) << 1);
            end
            3'd4: begin hi = s >>> 12; return hi << 12; end
            default: return 64'd0;
        endcase
    endfunction

    // Per-cycle compare against the occupancy/FIFO model.
    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        exp_t e;
        cyc++;
        if (reset) begin
            q.delete();
            err_m = 1'b0;
            check("rst_ovld32", 64'(b32.out_valid), 64'd0);
            check("rst_ovld64", 64'(b64.out_valid), 64'd0);
            check("rst_irdy32", 64'(b32.in_ready), 64'd1);
        end else begin
            exp_rdy = (q.size() < 2);
            check("ovld32", 64'(b32.out_valid), 64'(q.size() != 0));
            check("ovld64", 64'(b64.out_valid), 64'(q.size() != 0));
            check("irdy32", 64'(b32.in_ready), 64'(exp_rdy));
            check("irdy64", 64'(b64.in_ready), 64'(exp_rdy));
            check("err32", 64'(b32.err_sticky), 64'(err_m));
            check("err64", 64'(b64.err_sticky), 64'(err_m));
            if (q.size() != 0) begin
                e = q[0];
                check("imm32", 64'(b32.out_immext), {32'd0, e.imm[31:0]});
                check("imm64", b64.out_immext, e.imm);
                check("tag32", 64'(b32.out_tag), 64'(e.tag));
                check("tag64", 64'(b64.out_tag), 64'(e.tag));
                check("ill32", 64'(b32.out_illegal), 64'(e.ill));
                if (out_ready) begin
                    void'(q.pop_front());
                    log_tag.push_back(int'(e.tag));
                    log_cyc.push_back(cyc);
                end
            end
            acc = in_valid && exp_rdy;
            if (acc) begin
                e.imm = model_imm(in_immsrc, in_word);
                e.tag = in_tag;
                e.ill = (in_immsrc > 3'd4);
                q.push_back(e);
            end
            if (err_clr) err_m = 1'b0;
            else if (acc && in_immsrc > 3'd4) err_m = 1'b1;
        end
    end

    // Present one beat (called at posedge+#1); returns at posedge+#1 after
    // the edge that accepted it.
    task automatic put(input logic [2:0] f, input logic [31:0] ins, input logic [4:0] t);
        int guard;
        guard     = 0;
        in_valid  = 1'b1;
        in_immsrc = f;
        in_word   = ins;
        in_tag    = t;
        @(negedge clk);
        while (!b32.in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL put_timeout: in_ready stuck at %0b, required 1", b32.in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [2:0]  bp_fmt [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [31:0] bp_ins [6] = '{32'h80000013, 32'h7FF0AFA3, 32'h80001063,
                                32'h0010006F, 32'hABCDE037, 32'h7FF00013};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        in_immsrc = 3'd0;
        in_word   = 32'd0;
        in_tag    = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_imm", 64'(b32.out_immext), 64'd0);
        check("reset_tag", 64'(b32.out_tag), 64'd0);
        check("reset_ill", 64'(b32.out_illegal), 64'd0);
        check("reset_err", 64'(b32.err_sticky), 64'd0);
        check("reset_rdy", 64'(b32.in_ready), 64'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Each format, checked one cycle after acceptance.
        put(3'd0, 32'hFFF00093, 5'd1);
        check("I_vld", 64'(b32.out_valid), 64'd1);
        check("I_imm", 64'(b32.out_immext), 64'hFFFFFFFF);
        check("I_ill", 64'(b32.out_illegal), 64'd0);
        check("I_tag", 64'(b32.out_tag), 64'd1);
        put(3'd1, 32'hFE20AE23, 5'd2);
        check("S_imm", 64'(b32.out_immext), 64'hFFFFFFFC);
        put(3'd2, 32'hFE000CE3, 5'd3);
        check("B_imm", 64'(b32.out_immext), 64'hFFFFFFF8);
        put(3'd3, 32'hFFDFF06F, 5'd4);
        check("J_imm", 64'(b32.out_immext), 64'hFFFFFFFC);
        check("J_imm64", b64.out_immext, 64'hFFFFFFFFFFFFFFFC);
        put(3'd4, 32'h123450B7, 5'd5);
        check("U_imm", 64'(b32.out_immext), 64'h12345000);
        check("U_imm64", b64.out_immext, 64'h0000000012345000);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: six beats back-to-back, consumer stalls cycles 2-5.
        log_tag.delete();
        log_cyc.delete();
        fork
            begin
                for (int i = 0; i < 6; i++) put(bp_fmt[i], bp_ins[i], 5'(i + 1));
            end
            begin
                out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", 64'(log_tag.size()), 64'd6);
        for (int i = 0; i < 6 && i < log_tag.size(); i++) begin
            check("bp_order", 64'(log_tag[i]), 64'(i + 1));
            if (i > 0) check("bp_rate", 64'(log_cyc[i] - log_cyc[i-1]), 64'd1);
        end

        // Illegal selects and the sticky flag.
        put(3'd7, 32'h12345678, 5'd9);
        check("ill_imm", 64'(b32.out_immext), 64'd0);
        check("ill_flag", 64'(b32.out_illegal), 64'd1);
        check("ill_err", 64'(b32.err_sticky), 64'd1);
        err_clr = 1'b1;
        put(3'd5, 32'hFFFFFFFF, 5'd10);
        err_clr = 1'b0;
        check("clr_wins", 64'(b32.err_sticky), 64'd0);
        check("clr_ill", 64'(b32.out_illegal), 64'd1);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset with both entries occupied.
        out_ready = 1'b0;
        put(3'd0, 32'h00100093, 5'd11);
        put(3'd0, 32'h00200093, 5'd12);
        check("full_rdy", 64'(b32.in_ready), 64'd0);
        check("full_vld", 64'(b32.out_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_vld", 64'(b32.out_valid), 64'd0);
        check("arst_rdy", 64'(b32.in_ready), 64'd1);
        check("arst_tag", 64'(b32.out_tag), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        put(3'd0, 32'h00500093, 5'd13);
        check("post_vld", 64'(b32.out_valid), 64'd1);
        check("post_tag", 64'(b32.out_tag), 64'd13);
        check("post_imm", 64'(b32.out_immext), 64'd5);
        @(posedge clk);
        #1;
        check("post_alone", 64'(b32.out_valid), 64'd0);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
